// File: rtl/mag_sq_framer.sv
// mag_sq_framer
//   Turns a stream of complex FFT bins into a fixed-length stream of scaled,
//   saturated magnitude-squared values (re^2 + im^2) for spectral_flux.
//   Every frame delivers exactly N bins. Bins beyond the N-th are accepted
//   and dropped. Short frames are zero-padded up to N. After the last bin of
//   a frame has been pushed, GAP idle cycles pass before the next frame is
//   accepted.
//
// Ports
//   clk        in   1     system clock, rising edge
//   reset      in   1     asynchronous reset, active low
//   fft_valid  in   1     input bin valid
//   fft_ready  out  1     bin is taken on a rising edge where fft_valid & fft_ready
//   fft_re     in   IN_W  signed real part
//   fft_im     in   IN_W  signed imaginary part
//   fft_last   in   1     final bin of the FFT frame
//   mag_valid  out  1     one-cycle strobe per output bin, no backpressure
//   mag_sq     out  W     (re^2 + im^2) >> SHIFT, saturated to W bits
//   frame_done out  1     pulse with the N-th mag_valid of a frame
//   frame_err  out  1     pulse with frame_done when the frame was zero-padded
//
// Handshake: a bin transfers on a rising clk edge where fft_valid and
// fft_ready are both 1. A source that sees fft_ready low keeps fft_valid and
// its data unchanged; nothing is captured on such an edge. The output side
// has no ready: mag_valid is a single-cycle strobe per bin.
module mag_sq_framer #(
    parameter int IN_W  = 16,
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int SHIFT = 16,
    parameter int GAP   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fft_valid,
    output logic            fft_ready,
    input  logic [IN_W-1:0] fft_re,
    input  logic [IN_W-1:0] fft_im,
    input  logic            fft_last,
    output logic            mag_valid,
    output logic [W-1:0]    mag_sq,
    output logic            frame_done,
    output logic            frame_err
);

    localparam int CW = $clog2(N);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int PW = 2 * IN_W;
    localparam int SW = 2 * IN_W + 1;

    localparam logic [1:0] ST_STREAM  = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_PAD     = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    localparam logic [CW-1:0] LAST_BIN = CW'(N - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP - 1);

    logic [1:0]    state;
    logic [CW-1:0] bin_cnt;
    logic [GW-1:0] gap_cnt;
    logic          started;   // holds fft_ready low until the first edge after reset

    logic accept;
    logic in_pad;
    logic push;
    logic push_end;

    assign fft_ready = started & ((state == ST_STREAM) | (state == ST_DISCARD));
    assign accept    = fft_valid & fft_ready;
    assign in_pad    = (state == ST_PAD);
    // Real bins enter only while streaming; pad bins enter every PAD cycle.
    assign push      = ((state == ST_STREAM) & accept) | in_pad;
    assign push_end  = push & (bin_cnt == LAST_BIN);

    // Frame control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_STREAM;
            bin_cnt <= '0;
            gap_cnt <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                ST_STREAM: begin
                    if (accept) begin
                        if (bin_cnt == LAST_BIN) begin
                            state   <= fft_last ? ST_GAP : ST_DISCARD;
                            gap_cnt <= '0;
                        end else begin
                            bin_cnt <= bin_cnt + CW'(1);
                            if (fft_last) begin
                                state <= ST_PAD;
                            end
                        end
                    end
                end
                ST_DISCARD: begin
                    if (accept && fft_last) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end
                end
                ST_PAD: begin
                    if (bin_cnt == LAST_BIN) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end else begin
                        bin_cnt <= bin_cnt + CW'(1);
                    end
                end
                default: begin
                    if (gap_cnt == LAST_GAP) begin
                        state   <= ST_STREAM;
                        bin_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
            endcase
        end
    end

    // Stage 1: input register (pad bins enter as zero)
    logic            s1_valid, s1_end, s1_pad;
    logic [IN_W-1:0] s1_re, s1_im;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_end   <= 1'b0;
            s1_pad   <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= push;
            s1_end   <= push_end;
            s1_pad   <= push_end & in_pad;
            s1_re    <= in_pad ? '0 : fft_re;
            s1_im    <= in_pad ? '0 : fft_im;
        end
    end

    // Stage 2: squares. Operands are sign-extended to PW bits so the low PW
    // bits of the product are the exact square, including (-2^(IN_W-1))^2.
    logic signed [PW-1:0] re_ext, im_ext;
    logic                 s2_valid, s2_end, s2_pad;
    logic [PW-1:0]        sq_re, sq_im;

    assign re_ext = {{IN_W{s1_re[IN_W-1]}}, s1_re};
    assign im_ext = {{IN_W{s1_im[IN_W-1]}}, s1_im};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_end   <= 1'b0;
            s2_pad   <= 1'b0;
            sq_re    <= '0;
            sq_im    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_end   <= s1_end;
            s2_pad   <= s1_pad;
            sq_re    <= re_ext * re_ext;
            sq_im    <= im_ext * im_ext;
        end
    end

    // Stage 3: add, shift, saturate. The shifted sum is zero-extended so the
    // saturation compare is valid whether W is narrower or wider than SW.
    logic [SW-1:0]  sum, shifted;
    logic [SW+W:0]  wide;
    logic [W-1:0]   mag_next;

    assign sum      = {1'b0, sq_re} + {1'b0, sq_im};
    assign shifted  = sum >> SHIFT;
    assign wide     = {{(W+1){1'b0}}, shifted};
    assign mag_next = (wide > {{(SW+1){1'b0}}, {W{1'b1}}}) ? {W{1'b1}} : wide[W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_valid  <= 1'b0;
            mag_sq     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            mag_valid  <= s2_valid;
            mag_sq     <= s2_valid ? mag_next : '0;
            frame_done <= s2_valid & s2_end;
            frame_err  <= s2_valid & s2_pad;
        end
    end

endmodule

// File: tb/tb_mag_sq_framer.sv
// tb_mag_sq_framer
//   Two framer instances share one input stream: u_a with SHIFT=16 and u_b
//   with SHIFT=8. A reference model predicts, per clock cycle, fft_ready and
//   every output bin of both instances from frame-level rules (bins accepted
//   per frame, output three cycles after acceptance, zero padding, GAP idle
//   cycles). Scenario tasks add their own checks on collected outputs.
module tb_mag_sq_framer;

    localparam int IN_W = 16;
    localparam int W    = 16;
    localparam int N    = 8;
    localparam int GAP  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            fft_valid = 1'b0;
    logic [IN_W-1:0] fft_re = '0;
    logic [IN_W-1:0] fft_im = '0;
    logic            fft_last = 1'b0;

    logic            fft_ready, mag_valid, frame_done, frame_err;
    logic [W-1:0]    mag_sq;
    logic            ready_b, valid_b, done_b, err_b;
    logic [W-1:0]    mag_b;

    mag_sq_framer #(.IN_W(IN_W), .W(W), .N(N), .SHIFT(16), .GAP(GAP)) u_a (
        .clk(clk), .reset(reset),
        .fft_valid(fft_valid), .fft_ready(fft_ready),
        .fft_re(fft_re), .fft_im(fft_im), .fft_last(fft_last),
        .mag_valid(mag_valid), .mag_sq(mag_sq),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    mag_sq_framer #(.IN_W(IN_W), .W(W), .N(N), .SHIFT(8), .GAP(GAP)) u_b (
        .clk(clk), .reset(reset),
        .fft_valid(fft_valid), .fft_ready(ready_b),
        .fft_re(fft_re), .fft_im(fft_im), .fft_last(fft_last),
        .mag_valid(valid_b), .mag_sq(mag_b),
        .frame_done(done_b), .frame_err(err_b)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int          at;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        bit          dn;
        bit          er;
    } exp_t;

    exp_t exp_q[$];
    bit   m_started = 1'b0;
    bit   m_discard = 1'b0;
    int   m_idx = 0;
    int   m_resume = 0;

    function automatic logic [W-1:0] ref_mag(input int re, input int im, input int sh);
        longint s;
        s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        s = s >> sh;
        if (s > 65535) return 16'hFFFF;
        return 16'(s);
    endfunction

    // observed outputs, consumed by the scenario tasks
    logic [W-1:0] obs_a[$];
    logic [W-1:0] obs_b[$];
    int           obs_cyc[$];
    int           acc_q[$];
    int           done_cnt = 0;
    int           err_cnt = 0;

    always @(negedge clk) begin
        bit   er_rdy, hit;
        exp_t ex;
        int   r, i;
        if (!reset) begin
            vectors++;
            if ({fft_ready, mag_valid, mag_sq, frame_done, frame_err,
                 ready_b, valid_b, mag_b, done_b, err_b} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d ready=%b valid=%b mag=%h done=%b err=%b (b: %b %b %h %b %b) required all 0",
                         cyc, fft_ready, mag_valid, mag_sq, frame_done, frame_err,
                         ready_b, valid_b, mag_b, done_b, err_b);
            end
            exp_q.delete();
            m_started = 1'b0;
            m_discard = 1'b0;
            m_idx     = 0;
            m_resume  = 0;
        end else begin
            er_rdy = m_started && (cyc >= m_resume);
            vectors++;
            if (fft_ready !== er_rdy || ready_b !== er_rdy) begin
                miscompares++;
                $display("FAIL ready cyc=%0d got a=%b b=%b required %b", cyc, fft_ready, ready_b, er_rdy);
            end

            hit = (exp_q.size() > 0) && (exp_q[0].at == cyc);
            if (hit) ex = exp_q.pop_front();
            else     ex = '{cyc, '0, '0, 1'b0, 1'b0};

            vectors++;
            if ({mag_valid, frame_done, frame_err} !== {hit, ex.dn, ex.er} ||
                {valid_b, done_b, err_b} !== {hit, ex.dn, ex.er}) begin
                miscompares++;
                $display("FAIL out_flags cyc=%0d got valid/done/err a=%b%b%b b=%b%b%b required %b%b%b",
                         cyc, mag_valid, frame_done, frame_err, valid_b, done_b, err_b, hit, ex.dn, ex.er);
            end
            if (hit) begin
                vectors++;
                if (mag_sq !== ex.va || mag_b !== ex.vb) begin
                    miscompares++;
                    $display("FAIL mag_sq cyc=%0d got a=%h b=%h required a=%h b=%h",
                             cyc, mag_sq, mag_b, ex.va, ex.vb);
                end
            end

            if (mag_valid === 1'b1) begin
                obs_a.push_back(mag_sq);
                obs_b.push_back(mag_b);
                obs_cyc.push_back(cyc);
            end
            if (frame_done === 1'b1) done_cnt++;
            if (frame_err === 1'b1)  err_cnt++;

            // frame rules: first N bins out 3 cycles after acceptance, short
            // frames padded with zero bins right after the last one, then GAP
            if (er_rdy && fft_valid === 1'b1) begin
                r = int'($signed(fft_re));
                i = int'($signed(fft_im));
                if (!m_discard) begin
                    m_idx++;
                    exp_q.push_back('{cyc + 3, ref_mag(r, i, 16), ref_mag(r, i, 8), m_idx == N, 1'b0});
                    if (fft_last) begin
                        for (int k = 1; k <= N - m_idx; k++)
                            exp_q.push_back('{cyc + 3 + k, '0, '0, k == N - m_idx, k == N - m_idx});
                        m_resume = cyc + (N - m_idx) + GAP + 1;
                        m_idx    = 0;
                    end else if (m_idx == N) begin
                        m_discard = 1'b1;
                    end
                end else if (fft_last) begin
                    m_discard = 1'b0;
                    m_idx     = 0;
                    m_resume  = cyc + GAP + 1;
                end
            end
            m_started = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_b.delete();
        obs_cyc.delete();
        acc_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send_bin(input int re, input int im, input bit last);
        int t;
        bit acc;
        fft_valid = 1'b1;
        fft_re    = 16'(re);
        fft_im    = 16'(im);
        fft_last  = last;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = fft_ready;
            if (acc) acc_q.push_back(cyc);
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout got no fft_ready in %0d cycles required acceptance", t);
        end
    endtask

    task automatic send_frame(input int len, input int re0, input int im0,
                              input bit rnd, input bit gaps, input bit hold);
        int re, im, n;
        for (int b = 0; b < len; b++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                if (n > 0) begin
                    fft_valid = 1'b0;
                    wait_cycles(n);
                end
            end
            re = rnd ? int'($urandom_range(0, 65535)) - 32768 : re0;
            im = rnd ? int'($urandom_range(0, 65535)) - 32768 : im0;
            send_bin(re, im, b == len - 1);
        end
        if (!hold) fft_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset     = 1'b0;
        fft_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (fft_ready !== 1'b0 || mag_valid !== 1'b0 || mag_sq !== '0 ||
            frame_done !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got ready=%b valid=%b mag=%h done=%b err=%b required all 0",
                     fft_ready, mag_valid, mag_sq, frame_done, frame_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (fft_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge got %b required 0", fft_ready);
        end
        @(negedge clk);
        vectors++;
        if (fft_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_edge got %b required 1", fft_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_exact_frame();
        clear_obs();
        send_frame(8, 1024, 768, 1'b0, 1'b0, 1'b0);
        wait_cycles(20);
        vectors++;
        if (obs_a.size() != 8) begin
            miscompares++;
            $display("FAIL exact_count got %0d required 8", obs_a.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (obs_a[k] !== 16'd25) begin
                    miscompares++;
                    $display("FAIL exact_value bin=%0d got %0d required 25", k, obs_a[k]);
                end
            end
            vectors++;
            if (obs_cyc[0] != acc_q[0] + 3) begin
                miscompares++;
                $display("FAIL exact_latency got %0d required %0d", obs_cyc[0] - acc_q[0], 3);
            end
        end
        vectors++;
        if (done_cnt != 1 || err_cnt != 0) begin
            miscompares++;
            $display("FAIL exact_done got done=%0d err=%0d required done=1 err=0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_saturate();
        clear_obs();
        send_bin(-32768, -32768, 1'b0);
        send_bin(16, 0, 1'b0);
        for (int b = 2; b < 8; b++)
            send_bin(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, b == 7);
        fft_valid = 1'b0;
        wait_cycles(20);
        vectors++;
        if (obs_b.size() < 2) begin
            miscompares++;
            $display("FAIL sat_count got %0d required 8", obs_b.size());
        end else begin
            vectors++;
            if (obs_b[0] !== 16'hFFFF || obs_a[0] !== 16'h8000) begin
                miscompares++;
                $display("FAIL sat_min_square got b=%h a=%h required b=ffff a=8000", obs_b[0], obs_a[0]);
            end
            vectors++;
            if (obs_b[1] !== 16'h0001 || obs_a[1] !== 16'h0000) begin
                miscompares++;
                $display("FAIL sat_small got b=%h a=%h required b=0001 a=0000", obs_b[1], obs_a[1]);
            end
        end
    endtask

    task automatic test_discard();
        clear_obs();
        send_frame(16, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        vectors++;
        if (obs_a.size() != 8 || acc_q.size() != 16) begin
            miscompares++;
            $display("FAIL discard_count got out=%0d accepted=%0d required out=8 accepted=16",
                     obs_a.size(), acc_q.size());
        end
        vectors++;
        if (done_cnt != 1 || err_cnt != 0) begin
            miscompares++;
            $display("FAIL discard_done got done=%0d err=%0d required done=1 err=0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_short_frame(input int len, input int re0, input bit rnd);
        clear_obs();
        send_frame(len, re0, 0, rnd, 1'b0, 1'b0);
        wait_cycles(25);
        vectors++;
        if (obs_a.size() != 8) begin
            miscompares++;
            $display("FAIL short_count len=%0d got %0d required 8", len, obs_a.size());
        end else begin
            for (int k = (rnd ? len : 0); k < 8; k++) begin
                vectors++;
                if (obs_a[k] !== ((k < len) ? 16'd1 : 16'd0)) begin
                    miscompares++;
                    $display("FAIL short_value len=%0d bin=%0d got %0d required %0d",
                             len, k, obs_a[k], (k < len) ? 1 : 0);
                end
            end
        end
        vectors++;
        if (done_cnt != 1 || err_cnt != 1) begin
            miscompares++;
            $display("FAIL short_done len=%0d got done=%0d err=%0d required done=1 err=1", len, done_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_frame(8, 0, 0, 1'b1, 1'b0, 1'b1);
        send_frame(8, 0, 0, 1'b1, 1'b0, 1'b1);
        send_frame(3, 0, 0, 1'b1, 1'b0, 1'b1);
        send_frame(8, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        vectors++;
        if (acc_q.size() != 27) begin
            miscompares++;
            $display("FAIL b2b_accepts got %0d required 27", acc_q.size());
        end else begin
            vectors++;
            if (acc_q[1] - acc_q[0] != 1) begin
                miscompares++;
                $display("FAIL b2b_stream got spacing %0d required 1", acc_q[1] - acc_q[0]);
            end
            vectors++;
            if (acc_q[8] - acc_q[7] != GAP + 1 || acc_q[16] - acc_q[15] != GAP + 1) begin
                miscompares++;
                $display("FAIL b2b_gap got ready-low %0d,%0d required %0d",
                         acc_q[8] - acc_q[7] - 1, acc_q[16] - acc_q[15] - 1, GAP);
            end
            vectors++;
            if (acc_q[19] - acc_q[18] != (N - 3) + GAP + 1) begin
                miscompares++;
                $display("FAIL b2b_pad_gap got ready-low %0d required %0d",
                         acc_q[19] - acc_q[18] - 1, (N - 3) + GAP);
            end
        end
        vectors++;
        if (obs_a.size() != 32 || done_cnt != 4 || err_cnt != 1) begin
            miscompares++;
            $display("FAIL b2b_outputs got out=%0d done=%0d err=%0d required out=32 done=4 err=1",
                     obs_a.size(), done_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        for (int b = 0; b < 3; b++)
            send_bin(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (mag_valid !== 1'b0 || mag_sq !== '0 || fft_ready !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs got valid=%b mag=%h ready=%b done=%b required all 0",
                     mag_valid, mag_sq, fft_ready, frame_done);
        end
        fft_valid = 1'b0;
        @(posedge clk);
        #1;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(6);
        vectors++;
        if (obs_a.size() != 0 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL midreset_dropped got out=%0d done=%0d required out=0 done=0", obs_a.size(), done_cnt);
        end
        clear_obs();
        send_frame(8, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        vectors++;
        if (obs_a.size() != 8 || done_cnt != 1 || err_cnt != 0) begin
            miscompares++;
            $display("FAIL midreset_next got out=%0d done=%0d err=%0d required out=8 done=1 err=0",
                     obs_a.size(), done_cnt, err_cnt);
        end
    endtask

    task automatic test_random_frames();
        int len;
        for (int f = 0; f < 12; f++) begin
            clear_obs();
            len = $urandom_range(1, 14);
            send_frame(len, 0, 0, 1'b1, 1'b1, 1'b0);
            wait_cycles(25);
            vectors++;
            if (obs_a.size() != N || done_cnt != 1 || err_cnt != ((len < N) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL random_frame len=%0d got out=%0d done=%0d err=%0d required out=%0d done=1 err=%0d",
                         len, obs_a.size(), done_cnt, err_cnt, N, (len < N) ? 1 : 0);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_exact_frame();
        test_saturate();
        test_discard();
        test_short_frame(5, 256, 1'b0);
        test_short_frame(1, 0, 1'b1);
        test_back_to_back();
        test_reset_midframe();
        test_random_frames();
        wait_cycles(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        vectors++;
        miscompares++;
        $display("FAIL watchdog got no completion by cycle %0d required completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
